// File: rtl/load_store_unit_if.sv
// Request/response and data-RAM bundle for the load/store unit.
// The master side is the core (and the RAM model); the slave side is the LSU.
interface load_store_unit_if #(
    parameter int ADDR_W = 10
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic              rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_din;
    logic [31:0]       ram_dout;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  ram_addr, ram_re, ram_we, ram_din
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, ram_dout,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output ram_addr, ram_re, ram_we, ram_din
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: one RV32I B/H/W access at a time against a word-wide RAM
// without byte enables. Sub-word stores are read-modify-write.
module load_store_unit #(
    parameter int ADDR_W = 10
) (
    input  logic                clk_i,
    input  logic                rst_i,
    load_store_unit_if.slave    bus
);
    typedef enum logic [2:0] {IDLE, RD, CAPT, WR, RESP} state_t;

    state_t            state_q, state_d;
    logic              st_q, st_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic              ram_re_q, ram_re_d;
    logic              ram_we_q, ram_we_d;
    logic [31:0]       ram_din_q, ram_din_d;

    logic              req_err;
    logic [4:0]        lane_shamt;
    logic [31:0]       lane_sh, lane_mask, load_val, merged;
    logic              unused_addr_bits;

    // Byte address bits above the RAM depth are deliberately dropped (wrap).
    assign unused_addr_bits = ^bus.req_addr[31:ADDR_W+2];

    assign bus.req_ready = (state_q == IDLE) & ~rst_i;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_re    = ram_re_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_din   = ram_din_q;

    // Classify the incoming request: illegal size code or misaligned address.
    always_comb begin
        req_err = 1'b0;
        case (bus.req_funct3)
            3'b000:  req_err = 1'b0;
            3'b001:  req_err = bus.req_addr[0];
            3'b010:  req_err = |bus.req_addr[1:0];
            3'b100:  req_err = bus.req_we;
            3'b101:  req_err = bus.req_we | bus.req_addr[0];
            default: req_err = 1'b1;
        endcase
    end

    // Lane steering: extract/extend for loads, lane merge for sub-word stores.
    always_comb begin
        lane_shamt = {off_q, 3'b000};
        lane_sh    = bus.ram_dout >> lane_shamt;
        lane_mask  = f3_q[0] ? 32'h0000_FFFF : 32'h0000_00FF;
        merged     = (bus.ram_dout & ~(lane_mask << lane_shamt))
                   | ((wdata_q & lane_mask) << lane_shamt);
        case (f3_q[1:0])
            2'b00:   load_val = f3_q[2] ? {24'h0, lane_sh[7:0]}
                                        : {{24{lane_sh[7]}}, lane_sh[7:0]};
            2'b01:   load_val = f3_q[2] ? {16'h0, lane_sh[15:0]}
                                        : {{16{lane_sh[15]}}, lane_sh[15:0]};
            default: load_val = bus.ram_dout;
        endcase
    end

    // Next-state and registered-output decode; strobes default low each cycle.
    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        f3_d        = f3_q;
        off_d       = off_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = 32'h0;
        ram_addr_d  = ram_addr_q;
        ram_re_d    = 1'b0;
        ram_we_d    = 1'b0;
        ram_din_d   = ram_din_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    st_d    = bus.req_we;
                    f3_d    = bus.req_funct3;
                    off_d   = bus.req_addr[1:0];
                    wdata_d = bus.req_wdata;
                    if (req_err) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        ram_addr_d = bus.req_addr[ADDR_W+1:2];
                        if (bus.req_we && bus.req_funct3 == 3'b010) begin
                            state_d   = WR;
                            ram_we_d  = 1'b1;
                            ram_din_d = bus.req_wdata;
                        end else begin
                            state_d  = RD;
                            ram_re_d = 1'b1;
                        end
                    end
                end
            end
            RD:   state_d = CAPT;
            CAPT: begin
                if (st_q) begin
                    state_d   = WR;
                    ram_we_d  = 1'b1;
                    ram_din_d = merged;
                end else begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_val;
                end
            end
            WR: begin
                state_d     = RESP;
                rsp_valid_d = 1'b1;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset aborts any access in flight.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            st_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            wdata_q     <= 32'h0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'h0;
            ram_addr_q  <= '0;
            ram_re_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_din_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            f3_q        <= f3_d;
            off_q       <= off_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            ram_addr_q  <= ram_addr_d;
            ram_re_q    <= ram_re_d;
            ram_we_q    <= ram_we_d;
            ram_din_q   <= ram_din_d;
        end
    end
endmodule
